// File: rtl/alu_arbiter.sv
// Round-robin front end that shares one registered 16-bit ALU between two requesters.
// One operation in flight: IDLE accepts, ISSUE pulses the ALU, CAPTURE latches, RESP holds.
module alu_arbiter #(
    parameter int                DATA_W = 16,
    parameter int                OP_W   = 4,
    parameter logic [OP_W-1:0]   MAX_OP = OP_W'(4'b1011)
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_carry,
    output logic              rsp_overflow,
    output logic              rsp_illegal,

    output logic              busy,

    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op_code,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t                   state;
    logic                     last_grant;

    logic [1:0]               vld;
    logic [1:0][OP_W-1:0]     op;
    logic [1:0][DATA_W-1:0]   opa;
    logic [1:0][DATA_W-1:0]   opb;

    logic                     win;
    logic                     accept;

    assign vld = {req1_valid, req0_valid};
    assign op  = {req1_op, req0_op};
    assign opa = {req1_a, req0_a};
    assign opb = {req1_b, req0_b};

    // A lone requester always wins; on contention the one not granted last time wins.
    always_comb begin
        win = vld[1];
        if (vld == 2'b11)
            win = ~last_grant;
    end

    assign accept = (state == S_IDLE) && (|vld);

    // Gated with reset_n so the handshake outputs read 0 while reset is held.
    assign req0_ready = reset_n && accept && !win;
    assign req1_ready = reset_n && accept &&  win;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            last_grant   <= 1'b1;
            alu_enable   <= 1'b0;
            alu_op_code  <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_carry    <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_illegal  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op_code <= op[win];
                        alu_a       <= opa[win];
                        alu_b       <= opb[win];
                        alu_enable  <= 1'b1;
                        rsp_id      <= win;
                        rsp_illegal <= (op[win] > MAX_OP);
                        last_grant  <= win;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    alu_enable <= 1'b0;
                    state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    rsp_result   <= alu_result;
                    rsp_zero     <= alu_zero;
                    rsp_carry    <= alu_carry;
                    rsp_overflow <= alu_overflow;
                    rsp_valid    <= 1'b1;
                    state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a stand-in registered ALU, a round-robin reference
// model that predicts each grant and response, and a monitor that checks every cycle.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_result;
    logic        rsp_zero, rsp_carry, rsp_overflow, rsp_illegal, busy;
    logic        alu_enable;
    logic [3:0]  alu_op_code;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result = '0;
    logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_overflow = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_overflow(rsp_overflow), .rsp_illegal(rsp_illegal), .busy(busy),
        .alu_enable(alu_enable), .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        c;
        logic        v;
    } alu_out_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          fixed;
        alu_out_t    exp;
    } tx_t;

    typedef struct {
        bit          id;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        alu_out_t    out;
        bit          ill;
        int          t_acc;
    } exp_t;

    // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7..10 NOT a, 11 MUL, above: 16'hDEAD.
    function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_out_t    o;
        logic [16:0] s;
        logic [31:0] p;
        o = '0;
        s = '0;
        p = '0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                o.res = s[15:0];
                o.c = s[16];
                o.v = (a[15] == b[15]) && (o.res[15] != a[15]);
            end
            4'd1: begin
                s = {1'b0, a} - {1'b0, b};
                o.res = s[15:0];
                o.c = (a < b);
                o.v = (a[15] != b[15]) && (o.res[15] != a[15]);
            end
            4'd2: o.res = a & b;
            4'd3: o.res = a | b;
            4'd4: o.res = a ^ b;
            4'd5: o.res = a << b[3:0];
            4'd6: o.res = a >> b[3:0];
            4'd11: begin
                p = {16'h0, a} * {16'h0, b};
                o.res = p[15:0];
                o.c = |p[31:16];
                o.v = |p[31:16];
            end
            default: o.res = (op > 4'd11) ? 16'hDEAD : ~a;
        endcase
        o.z = (o.res == 16'h0);
        return o;
    endfunction

    always @(posedge clk)
        if (alu_enable)
            {alu_result, alu_zero, alu_carry, alu_overflow} <= alu_fn(alu_op_code, alu_a, alu_b);

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   m_last = 1'b1;
    int   bp_cnt = 0;
    bit   bp_rand = 1'b0;
    tx_t  pend0[$];
    tx_t  pend1[$];
    exp_t exp_q[$];
    int   grant_log[$];
    int   en_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic tx_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        tx_t t;
        t.op = op; t.a = a; t.b = b; t.fixed = 1'b0; t.exp = '0;
        return t;
    endfunction

    function automatic tx_t mkf(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic z, input logic c, input logic v);
        tx_t t;
        t = mk(op, a, b);
        t.fixed = 1'b1;
        t.exp = '{res: res, z: z, c: c, v: v};
        return t;
    endfunction

    task automatic drive_inputs();
        req0_valid = (pend0.size() > 0);
        req1_valid = (pend1.size() > 0);
        if (req0_valid) begin
            req0_op = pend0[0].op; req0_a = pend0[0].a; req0_b = pend0[0].b;
        end else begin
            req0_op = 4'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
        end
        if (req1_valid) begin
            req1_op = pend1[0].op; req1_a = pend1[0].a; req1_b = pend1[0].b;
        end else begin
            req1_op = 4'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
        end
    endtask

    // One clock: observe handshakes mid-cycle, predict the grant, then update inputs after the edge.
    task automatic cycle();
        bit   hs0, hs1, pred;
        tx_t  r;
        exp_t e;
        @(negedge clk);
        hs0 = req0_valid && req0_ready;
        hs1 = req1_valid && req1_ready;
        if (hs0 || hs1) begin
            pred = (req0_valid && req1_valid) ? !m_last : req1_valid;
            cmp("grant_id", 32'(hs1), 32'(pred));
            r = hs1 ? pend1[0] : pend0[0];
            e.id = pred; e.op = r.op; e.a = r.a; e.b = r.b;
            e.out = r.fixed ? r.exp : alu_fn(r.op, r.a, r.b);
            e.ill = (r.op > 4'd11);
            e.t_acc = cyc;
            exp_q.push_back(e);
            grant_log.push_back(int'(pred));
            m_last = pred;
        end
        @(posedge clk);
        #1;
        if (hs0) void'(pend0.pop_front());
        if (hs1) void'(pend1.pop_front());
        drive_inputs();
        if (bp_cnt > 0) begin
            rsp_ready = 1'b0;
            bp_cnt--;
        end else begin
            rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((pend0.size() > 0 || pend1.size() > 0 || exp_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        cmp("drain_in_budget", 32'(n < budget), 32'd1);
        pend0.delete(); pend1.delete(); exp_q.delete();
        drive_inputs();
    endtask

    // Monitor: response checks against the scoreboard plus per-cycle protocol checks.
    bit   prev_v = 1'b0;
    bit   prev_en = 1'b0;
    exp_t me;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
            prev_en = 1'b0;
        end else begin
            cmp("ready_onehot", 32'(req0_ready && req1_ready), 32'd0);
            if (busy) cmp("ready_while_busy", 32'(req0_ready || req1_ready), 32'd0);
            if (alu_enable) begin
                cmp("enable_one_cycle", 32'(prev_en), 32'd0);
                en_log.push_back(cyc);
                if (exp_q.size() > 0) begin
                    cmp("alu_op_code", 32'(alu_op_code), 32'(exp_q[$].op));
                    cmp("alu_a", 32'(alu_a), 32'(exp_q[$].a));
                    cmp("alu_b", 32'(alu_b), 32'(exp_q[$].b));
                end
            end
            if (exp_q.size() == 0) begin
                cmp("stale_rsp", 32'(rsp_valid), 32'd0);
            end else if (rsp_valid) begin
                me = exp_q[0];
                if (!prev_v) cmp("rsp_latency", 32'(cyc), 32'(me.t_acc + 3));
                cmp("rsp_id", 32'(rsp_id), 32'(me.id));
                cmp("rsp_result", 32'(rsp_result), 32'(me.out.res));
                cmp("rsp_zero", 32'(rsp_zero), 32'(me.out.z));
                cmp("rsp_carry", 32'(rsp_carry), 32'(me.out.c));
                cmp("rsp_overflow", 32'(rsp_overflow), 32'(me.out.v));
                cmp("rsp_illegal", 32'(rsp_illegal), 32'(me.ill));
                if (rsp_ready) void'(exp_q.pop_front());
            end
            prev_v = rsp_valid;
            prev_en = alu_enable;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i;
        bit  sel;
        rsp_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op = 4'd0; req0_a = 16'h1234; req0_b = 16'h5678;
        req1_op = 4'd1; req1_a = 16'h9abc; req1_b = 16'hdef0;

        // Reset state with both requesters asserting valid.
        repeat (2) @(negedge clk);
        cmp("rst_req0_ready", 32'(req0_ready), 32'd0);
        cmp("rst_req1_ready", 32'(req1_ready), 32'd0);
        cmp("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_alu_enable", 32'(alu_enable), 32'd0);
        cmp("rst_alu_ops", {alu_op_code, alu_a[11:0], alu_b}, 32'd0);
        cmp("rst_rsp_fields", {rsp_result, rsp_id, rsp_zero, rsp_carry, rsp_overflow, rsp_illegal}, 32'd0);
        @(posedge clk);
        #1;
        drive_inputs();
        reset_n = 1'b1;

        // Single ADD with signed overflow.
        pend0.push_back(mkf(4'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1));
        drive_inputs();
        drain(40);

        // Backpressure: SUB on req1 held in RESP while req0 waits.
        bp_cnt = 8;
        pend1.push_back(mkf(4'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b1, 1'b0));
        drive_inputs();
        cycle();
        pend0.push_back(mk(4'd2, 16'hF0F0, 16'h0FF0));
        drive_inputs();
        drain(60);

        // Illegal opcode is still issued and returns the ALU default.
        pend0.push_back(mkf(4'hF, 16'h1111, 16'h2222, 16'hDEAD, 1'b0, 1'b0, 1'b0));
        drive_inputs();
        drain(40);

        // Reset during ISSUE.
        pend0.push_back(mk(4'd0, 16'h0001, 16'h0002));
        drive_inputs();
        for (i = 0; i < 10; i++) begin
            cycle();
            if (alu_enable) break;
        end
        cmp("reached_issue", 32'(alu_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        cmp("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        cmp("midrst_alu_enable", 32'(alu_enable), 32'd0);
        cmp("midrst_busy", 32'(busy), 32'd0);
        pend0.delete(); pend1.delete(); exp_q.delete();
        m_last = 1'b1;
        drive_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Arbitration after reset: both requesters held valid for four operations.
        grant_log.delete();
        en_log.delete();
        pend0.push_back(mk(4'd0, 16'h0010, 16'h0020));
        pend0.push_back(mk(4'd3, 16'h0F00, 16'h00F0));
        pend1.push_back(mk(4'd1, 16'h0100, 16'h0001));
        pend1.push_back(mk(4'd4, 16'hAAAA, 16'h5555));
        drive_inputs();
        drain(60);
        cmp("arb_grants", 32'(grant_log.size()), 32'd4);
        for (i = 0; i < grant_log.size() && i < 4; i++)
            cmp("arb_grant_seq", 32'(grant_log[i]), 32'(i % 2));
        cmp("arb_enables", 32'(en_log.size()), 32'd4);
        for (i = 1; i < en_log.size(); i++)
            cmp("arb_enable_spacing", 32'(en_log[i] - en_log[i-1]), 32'd4);

        // Lone requester: two back-to-back MULs on req1.
        grant_log.delete();
        pend1.push_back(mkf(4'd11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b1));
        pend1.push_back(mkf(4'd11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 1'b1));
        drive_inputs();
        drain(60);
        cmp("lone_grants", 32'(grant_log.size()), 32'd2);

        // Randomized traffic with random backpressure.
        bp_rand = 1'b1;
        for (i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                sel = 1'($urandom_range(0, 1));
                if (sel && pend1.size() < 3)
                    pend1.push_back(mk(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom)));
                else if (!sel && pend0.size() < 3)
                    pend0.push_back(mk(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom)));
                drive_inputs();
            end
            cycle();
        end
        drain(400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
